// File: rtl/rst_seq_pkg.sv
// Shared types and constants for the reset sequencer.
// Optional button debounce is enabled by defining RST_SEQ_DEBOUNCE_EN.
package rst_seq_pkg;

  typedef enum logic [2:0] {
    ST_HOLD,
    ST_STRETCH,
    ST_REL_SYS,
    ST_REL_USB,
    ST_RUN
  } state_e;

  localparam int unsigned CAUSE_SW   = 2;
  localparam int unsigned CAUSE_EXT  = 1;
  localparam int unsigned CAUSE_LOCK = 0;

  // Counter wide enough to hold the largest of the three cycle counts.
  function automatic int unsigned cnt_width(input int unsigned a,
                                            input int unsigned b,
                                            input int unsigned c);
    int unsigned m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return $clog2(m + 1);
  endfunction

endpackage

// File: rtl/rst_seq_debounce.sv
// Button debouncer: accepts a new level only after DEBOUNCE_CYCLES equal samples.
// Only built when RST_SEQ_DEBOUNCE_EN is defined.
`ifdef RST_SEQ_DEBOUNCE_EN
module rst_seq_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 1024,
  parameter int unsigned CNT_W           = 11
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic level_i,
  output logic level_o
);

  logic [CNT_W-1:0] cnt;

  // Any sample matching the accepted level restarts the run.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      level_o <= 1'b1;
      cnt     <= '0;
    end else if (level_i == level_o) begin
      cnt <= '0;
    end else if (cnt == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
      level_o <= level_i;
      cnt     <= '0;
    end else if (cnt != '1) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

endmodule
`endif

// File: rtl/rst_seq_ctrl.sv
// Staged reset sequencer: holds resets while any cause is active, then releases sys, usb, periph.
// Define RST_SEQ_DEBOUNCE_EN to debounce the board reset button.
module rst_seq_ctrl
  import rst_seq_pkg::*;
#(
  parameter int unsigned STRETCH_CYCLES  = 16,
  parameter int unsigned STAGE_GAP       = 8,
  parameter int unsigned DEBOUNCE_CYCLES = 1024
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       pll_locked_i,
  input  logic       ext_rst_ni,
  input  logic       sw_rst_req_i,
  input  logic       clr_cause_i,
  output logic       rst_sys_no,
  output logic       rst_usb_no,
  output logic       rst_periph_no,
  output logic       seq_done_o,
  output logic [2:0] cause_o
);

  localparam int unsigned CNT_W = cnt_width(STRETCH_CYCLES, STAGE_GAP, DEBOUNCE_CYCLES);

  logic             ext_meta;
  logic             ext_sync;
  logic             btn_level;
  logic [2:0]       cause_src;
  logic             hold_req;
  state_e           state;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_inc;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      ext_meta <= 1'b1;
      ext_sync <= 1'b1;
    end else begin
      ext_meta <= ext_rst_ni;
      ext_sync <= ext_meta;
    end
  end

`ifdef RST_SEQ_DEBOUNCE_EN
  rst_seq_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .CNT_W          (CNT_W)
  ) u_debounce (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .level_i(ext_sync),
    .level_o(btn_level)
  );
`else
  assign btn_level = ext_sync;
`endif

  always_comb begin
    cause_src             = '0;
    cause_src[CAUSE_SW]   = sw_rst_req_i;
    cause_src[CAUSE_EXT]  = ~btn_level;
    cause_src[CAUSE_LOCK] = ~pll_locked_i;
  end

  assign hold_req = |cause_src;
  assign cnt_inc  = (cnt == '1) ? cnt : cnt + CNT_W'(1);

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state         <= ST_HOLD;
      cnt           <= '0;
      rst_sys_no    <= 1'b0;
      rst_usb_no    <= 1'b0;
      rst_periph_no <= 1'b0;
      seq_done_o    <= 1'b0;
      cause_o       <= '0;
    end else begin
      // Clearing and setting in one cycle: the set term is ORed after the clear.
      cause_o <= (clr_cause_i ? 3'b000 : cause_o) | cause_src;
      if (hold_req) begin
        state         <= ST_HOLD;
        cnt           <= '0;
        rst_sys_no    <= 1'b0;
        rst_usb_no    <= 1'b0;
        rst_periph_no <= 1'b0;
        seq_done_o    <= 1'b0;
      end else begin
        case (state)
          ST_HOLD: begin
            state <= ST_STRETCH;
            cnt   <= '0;
          end
          ST_STRETCH: begin
            if (cnt == CNT_W'(STRETCH_CYCLES - 1)) begin
              rst_sys_no <= 1'b1;
              state      <= ST_REL_SYS;
              cnt        <= '0;
            end else begin
              cnt <= cnt_inc;
            end
          end
          ST_REL_SYS: begin
            if (cnt == CNT_W'(STAGE_GAP - 1)) begin
              rst_usb_no <= 1'b1;
              state      <= ST_REL_USB;
              cnt        <= '0;
            end else begin
              cnt <= cnt_inc;
            end
          end
          ST_REL_USB: begin
            if (cnt == CNT_W'(STAGE_GAP - 1)) begin
              rst_periph_no <= 1'b1;
              seq_done_o    <= 1'b1;
              state         <= ST_RUN;
              cnt           <= '0;
            end else begin
              cnt <= cnt_inc;
            end
          end
          ST_RUN: begin
            cnt <= '0;
          end
          default: begin
            state <= ST_HOLD;
            cnt   <= '0;
          end
        endcase
      end
    end
  end

endmodule
